// File: rtl/mmio_pkg.sv
// Shared register-map offsets and LED write-mode encoding for the MMIO hub.
package mmio_pkg;

    localparam int unsigned MMIO_WORDS = 8;
    localparam int unsigned OFF_W      = $clog2(MMIO_WORDS);

    localparam logic [OFF_W-1:0] OFF_BTN_LEVEL = 3'd0;
    localparam logic [OFF_W-1:0] OFF_LED       = 3'd1;
    localparam logic [OFF_W-1:0] OFF_LED_SET   = 3'd2;
    localparam logic [OFF_W-1:0] OFF_LED_CLR   = 3'd3;
    localparam logic [OFF_W-1:0] OFF_LED_TGL   = 3'd4;
    localparam logic [OFF_W-1:0] OFF_BTN_PRESS = 3'd5;
    localparam logic [OFF_W-1:0] OFF_BTN_CODE  = 3'd6;

    typedef enum logic [1:0] {
        LED_WR,
        LED_SET,
        LED_CLR,
        LED_TGL
    } led_mode_e;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and a single-cycle pulse coinciding with the level's 0->1 transition.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int unsigned        CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;
    logic             settle;

    assign settle = (sync_b != level) && (cnt == CNT_MAX);
    assign rise   = settle && sync_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            if (sync_b != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync_b;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mmio_io_hub.sv
// Data-memory MMIO hub: claims an 8-word window for buttons and LEDs and
// passes all other accesses through to the data RAM.
module mmio_io_hub
    import mmio_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned NUM_LED         = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter logic [11:0] BASE_ADDR       = 12'h000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               bus_we,
    input  logic [11:0]        bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic [31:0]        ram_rdata,
    output logic [31:0]        bus_rdata,
    output logic               ram_we,
    output logic [NUM_LED-1:0] led
);

    logic               hit;
    logic [OFF_W-1:0]   offset;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] press_clr;
    logic [31:0]        btn_code;
    logic [31:0]        rd_val;
    logic [31:0]        mmio_q;
    logic               sel_q;
    logic               led_wr_en;
    led_mode_e          led_mode;
    logic [NUM_LED-1:0] led_wdata;
    logic [NUM_LED-1:0] led_next;
    logic               unused_wdata;

    assign hit          = (bus_addr[11:3] == BASE_ADDR[11:3]);
    assign offset       = bus_addr[2:0];
    assign ram_we       = bus_we & ~hit;
    assign led_wdata    = bus_wdata[NUM_LED-1:0];
    assign unused_wdata = ^bus_wdata;
    assign bus_rdata    = sel_q ? mmio_q : ram_rdata;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock  (clock),
            .reset  (reset),
            .btn_raw(btn_raw[g]),
            .level  (btn_level[g]),
            .rise   (btn_rise[g])
        );
    end

    always_comb begin
        led_wr_en = bus_we & hit;
        led_mode  = LED_WR;
        case (offset)
            OFF_LED:     led_mode = LED_WR;
            OFF_LED_SET: led_mode = LED_SET;
            OFF_LED_CLR: led_mode = LED_CLR;
            OFF_LED_TGL: led_mode = LED_TGL;
            default:     led_wr_en = 1'b0;
        endcase
    end

    always_comb begin
        led_next = led;
        case (led_mode)
            LED_WR:  led_next = led_wdata;
            LED_SET: led_next = led | led_wdata;
            LED_CLR: led_next = led & ~led_wdata;
            LED_TGL: led_next = led ^ led_wdata;
            default: led_next = led;
        endcase
    end

    always_comb begin
        press_clr = '0;
        if (bus_we && hit && offset == OFF_BTN_PRESS) begin
            press_clr = bus_wdata[NUM_BTN-1:0];
        end
    end

    // Lowest-numbered asserted button wins; code is index+1 so 0 means none.
    always_comb begin
        btn_code = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (btn_level[i] && btn_code == '0) begin
                btn_code = 32'(i + 1);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            OFF_BTN_LEVEL: rd_val[NUM_BTN-1:0] = btn_level;
            OFF_LED:       rd_val[NUM_LED-1:0] = led;
            OFF_BTN_PRESS: rd_val[NUM_BTN-1:0] = press_q;
            OFF_BTN_CODE:  rd_val = btn_code;
            default:       rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led     <= '0;
            press_q <= '0;
            sel_q   <= 1'b0;
            mmio_q  <= '0;
        end else begin
            if (led_wr_en) begin
                led <= led_next;
            end
            // Set is ORed in after the clear so a coincident rise survives W1C.
            press_q <= (press_q & ~press_clr) | btn_rise;
            sel_q   <= hit;
            mmio_q  <= rd_val;
        end
    end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed self-checking bench for mmio_io_hub with a short debounce window.
module tb_mmio_io_hub;

    localparam logic [31:0] RAM_VAL = 32'hCAFE_0123;

    logic        clock;
    logic        reset;
    logic [3:0]  btn_raw;
    logic        bus_we;
    logic [11:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] bus_rdata;
    logic        ram_we;
    logic [15:0] led;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] rdata;

    mmio_io_hub #(
        .NUM_BTN        (4),
        .NUM_LED        (16),
        .DEBOUNCE_CYCLES(4),
        .BASE_ADDR      (12'h000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .ram_rdata(ram_rdata),
        .bus_rdata(bus_rdata),
        .ram_we   (ram_we),
        .led      (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clock);
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        @(negedge clock);
        bus_we    = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge clock);
        bus_we   = 1'b0;
        bus_addr = a;
        @(negedge clock);
        d = bus_rdata;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        btn_raw   = 4'hF;
        bus_we    = 1'b1;
        bus_addr  = 12'h001;
        bus_wdata = 32'h0000_FFFF;
        ram_rdata = RAM_VAL;

        // Reset held with active write and buttons pressed
        wait_neg(4);
        check("rst_led", 32'(led), 32'h0);
        check("rst_rdata_ram", bus_rdata, RAM_VAL);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        btn_raw = 4'h0;
        bus_we  = 1'b0;
        reset   = 1'b1;
        wait_neg(1);
        check("post_rst_led", 32'(led), 32'h0);
        rd(12'h000, rdata);
        check("post_rst_level", rdata, 32'h0);

        // LED write modes
        wr(12'h001, 32'h0000_00F0);
        wr(12'h002, 32'h0000_0003);
        wr(12'h003, 32'h0000_0010);
        check("led_set_clr", 32'(led), 32'h0000_00E3);
        wr(12'h004, 32'h0000_8001);
        check("led_tgl", 32'(led), 32'h0000_80E2);
        rd(12'h001, rdata);
        check("led_read", rdata, 32'h0000_80E2);
        rd(12'h002, rdata);
        check("rd_set_zero", rdata, 32'h0);
        rd(12'h007, rdata);
        check("rd_rsvd_zero", rdata, 32'h0);
        wr(12'h000, 32'h0000_FFFF);
        wr(12'h007, 32'h0000_FFFF);
        check("ro_write_ignored", 32'(led), 32'h0000_80E2);
        @(negedge clock);
        bus_we    = 1'b1;
        bus_addr  = 12'h001;
        bus_wdata = 32'h0000_1234;
        @(negedge clock);
        bus_we    = 1'b0;
        check("rw_same_cycle_old", bus_rdata, 32'h0000_80E2);
        check("rw_same_cycle_led", 32'(led), 32'h0000_1234);

        // Debounce latency on button 2 (BTN_LEVEL read continuously)
        bus_addr = 12'h000;
        wait_neg(1);
        btn_raw[2] = 1'b1;
        wait_neg(6);
        check("db_not_edge5", bus_rdata, 32'h0);
        wait_neg(1);
        check("db_edge6", bus_rdata, 32'h4);

        // Short glitch on button 0
        btn_raw[0] = 1'b1;
        wait_neg(2);
        btn_raw[0] = 1'b0;
        wait_neg(10);
        check("glitch_level", bus_rdata, 32'h4);
        rd(12'h005, rdata);
        check("glitch_press", rdata, 32'h4);

        // Release button 2, press flag remains sticky, then W1C
        btn_raw[2] = 1'b0;
        wait_neg(8);
        rd(12'h000, rdata);
        check("btn2_released", rdata, 32'h0);
        rd(12'h005, rdata);
        check("press_sticky", rdata, 32'h4);
        wr(12'h005, 32'h0000_0004);
        rd(12'h005, rdata);
        check("press_w1c", rdata, 32'h0);

        // Button 1: press, release, clear, then coincident W1C and rise
        btn_raw[1] = 1'b1;
        wait_neg(8);
        btn_raw[1] = 1'b0;
        wait_neg(8);
        rd(12'h005, rdata);
        check("press_b1", rdata, 32'h2);
        wr(12'h005, 32'h0000_0002);
        rd(12'h005, rdata);
        check("press_b1_clr", rdata, 32'h0);
        @(negedge clock);
        btn_raw[1] = 1'b1;
        wait_neg(5);
        bus_we    = 1'b1;
        bus_addr  = 12'h005;
        bus_wdata = 32'h0000_0002;
        @(negedge clock);
        bus_we    = 1'b0;
        rd(12'h005, rdata);
        check("set_wins_w1c", rdata, 32'h2);

        // Priority encoder
        btn_raw[3] = 1'b1;
        wait_neg(8);
        rd(12'h006, rdata);
        check("code_b1_b3", rdata, 32'h2);
        rd(12'h000, rdata);
        check("level_b1_b3", rdata, 32'hA);
        btn_raw[1] = 1'b0;
        wait_neg(8);
        rd(12'h006, rdata);
        check("code_b3", rdata, 32'h4);
        btn_raw[3] = 1'b0;
        wait_neg(8);
        rd(12'h006, rdata);
        check("code_none", rdata, 32'h0);

        // RAM pass-through and window boundaries
        @(negedge clock);
        bus_we    = 1'b1;
        bus_addr  = 12'h010;
        bus_wdata = 32'h0000_5555;
        #1;
        check("ram_we_outside", 32'(ram_we), 32'h1);
        @(negedge clock);
        bus_addr  = 12'h008;
        #1;
        check("ram_we_edge8", 32'(ram_we), 32'h1);
        @(negedge clock);
        bus_addr  = 12'h001;
        bus_wdata = 32'h0000_00AA;
        #1;
        check("ram_we_inside", 32'(ram_we), 32'h0);
        @(negedge clock);
        bus_we   = 1'b0;
        bus_addr = 12'h010;
        check("led_after_pass", 32'(led), 32'h0000_00AA);
        @(negedge clock);
        check("pass_rdata", bus_rdata, RAM_VAL);

        // Asynchronous reset mid-access
        bus_addr = 12'h001;
        @(negedge clock);
        check("pre_async_rdata", bus_rdata, 32'h0000_00AA);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_rdata", bus_rdata, RAM_VAL);
        @(negedge clock);
        reset = 1'b1;
        rd(12'h001, rdata);
        check("after_async_led_rd", rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_io_hub.md
# mmio_io_hub

Memory-mapped I/O hub between the processor data-memory port and the data RAM. It claims a parametrised 8-word address window and serves everything else from RAM. Inside the window it provides:
- NUM_BTN debounced, synchronised button inputs with sticky press flags and a priority-encoded button code.
- A NUM_LED-wide LED register with direct, set, clear and toggle write modes.

It generalises the fixed button-at-0 and LED-at-1 decode into a configurable peripheral.

## Interface
Parameters:
- NUM_BTN, 4, number of button channels (1–16)
- NUM_LED, 16, LED register width (1–32)
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles needed to accept a level change (≥2)
- BASE_ADDR, 12'h000, word address of the window; bits [2:0] must be 0

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- btn_raw  in  NUM_BTN  raw button pins, asynchronous
- bus_we  in  1  data-memory write enable from processor
- bus_addr  in  12  data-memory word address
- bus_wdata  in  32  store data
- ram_rdata  in  32  read data from data RAM (1-cycle synchronous)
- bus_rdata  out  32  read data returned to processor
- ram_we  out  1  bus_we gated off when bus_addr hits window
- led  out  NUM_LED  LED register

## Operation
- hit = (bus_addr[11:3] == BASE_ADDR[11:3]); offset = bus_addr[2:0]; ram_we = bus_we & ~hit.
- Register map by offset (R = read, W = write):
  - 0 BTN_LEVEL (R): debounced levels, zero-extended.
  - 1 LED (R/W): led <= wdata[NUM_LED-1:0].
  - 2 LED_SET (W): led <= led | wdata.
  - 3 LED_CLR (W): led <= led & ~wdata.
  - 4 LED_TGL (W): led <= led ^ wdata.
  - 5 BTN_PRESS (R, write-1-to-clear): sticky press flags.
  - 6 BTN_CODE (R): index+1 of lowest-numbered asserted debounced button, 0 if none; zero-extended.
  - 7: reserved.
- Reads of offsets 2, 3, 4 and 7 return 0. Writes to read-only or reserved offsets are ignored. Reads never change state.
- Per-button channel:
  - 2-flop synchroniser feeds a counter of width $clog2(DEBOUNCE_CYCLES).
  - When sync ≠ stable, the counter increments; on reaching DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - When sync == stable, the counter clears.
- A press flag sets on the edge where stable goes 0→1.
- If a W1C write and a new rising edge hit the same bit in the same cycle, set wins.

## Timing
- Reset values: led = 0, stable = 0, press flags = 0, counters = 0, synchronisers = 0, sel_q = 0, mmio_q = 0. With sel_q = 0, bus_rdata = ram_rdata.
- Writes take effect at the rising edge where bus_we & hit is sampled. led is visible the following cycle.
- Read latency is 1 cycle, matching RAM:
  - sel_q <= hit; mmio_q <= selected register.
  - bus_rdata = sel_q ? mmio_q : ram_rdata (combinational mux).
- A read and a write to the same register in the same cycle return the pre-write value.
- Debounce latency: with btn_raw held, stable changes at the (DEBOUNCE_CYCLES+2)th rising edge after the change is first sampled. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.
- reset asserted mid-debounce or mid-access clears immediately. The first access after release behaves as after power-up.

## Structure
- Package mmio_pkg holds:
  - Offset constants OFF_BTN_LEVEL … OFF_BTN_CODE (3-bit).
  - LED write-mode enum {LED_WR, LED_SET, LED_CLR, LED_TGL}.
  - Window size constant MMIO_WORDS = 8.
- Sub-module btn_debounce (synchroniser, counter, stable flop, rise pulse), instantiated NUM_BTN times via generate.
- Decode, LED register, press flags, encoder and read mux stay in the top.

## Test plan
Use DEBOUNCE_CYCLES = 4, BASE_ADDR = 12'h000, NUM_BTN = 4, NUM_LED = 16.
- Reset: hold reset low, drive btn_raw = 4'hF, write LED = 16'hFFFF → led = 0, BTN_LEVEL read = 0; after release, led = 0.
- LED modes: write 1←16'h00F0, 2←16'h0003, 3←16'h0010, 4←16'h8001 → led = 16'h00E3, then 16'h80E2; LED read returns 32'h000080E2 one cycle after address.
- Debounce: btn_raw[2] 0→1 held → BTN_LEVEL = 32'h4 from edge 6, not edge 5. A 2-cycle pulse on btn_raw[0] → BTN_LEVEL and BTN_PRESS unchanged.
- Press flag / W1C: after btn 2 press and release, BTN_PRESS = 32'h4; write 5←32'h4 → 0. Same-cycle W1C and new rise on bit 1 → bit 1 remains 1.
- BTN_CODE: buttons 1 and 3 stable high → code = 2; only 3 → 4; none → 0.
- Pass-through: write/read at addr 12'h010 → ram_we = 1, bus_rdata = ram_rdata. Write at addr 12'h001 → ram_we = 0.
